// File: rtl/core_c1_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : core_c1_pipe_ctrl
// Purpose  : C1 RV32I hazard controller - load-use stall, MDU hold, redirect
//            flush and stall-cycle performance counter.
// Revision : 1.0 - initial release
// ============================================================================
module core_c1_pipe_ctrl #(
    parameter int MDU_CYCLES   = 4,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ifu_inst_valid,
    input  logic [4:0]       ifu_rs1_idx,
    input  logic [4:0]       ifu_rs2_idx,
    input  logic             ifu_rs1_used,
    input  logic             ifu_rs2_used,
    input  logic             exu_inst_valid,
    input  logic [4:0]       exu_rd_idx,
    input  logic             exu_is_load,
    input  logic             exu_mdu_op,
    input  logic             exu_redirect,
    output logic             exu_pause,
    output logic             ifu_stall,
    output logic             exu_bubble,
    output logic             ifu_flush,
    output logic             mdu_result_valid,
    output logic [CNT_W-1:0] perf_stall_cnt
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MDU_WAIT = 2'd1,
        FLUSH    = 2'd2
    } state_t;

    localparam logic [3:0]       MDU_LOAD   = 4'(MDU_CYCLES - 2);
    localparam logic [3:0]       FLUSH_LOAD = 4'(FLUSH_CYCLES - 2);
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state;
    logic [3:0]       cnt;
    logic [CNT_W-1:0] stall_cnt;

    logic mdu_start;
    logic redirect_hit;
    logic rs1_match;
    logic rs2_match;
    logic load_use;

    assign mdu_start    = exu_inst_valid & exu_mdu_op;
    assign redirect_hit = exu_inst_valid & exu_redirect & ~exu_mdu_op;
    assign rs1_match    = ifu_rs1_used & (ifu_rs1_idx == exu_rd_idx);
    assign rs2_match    = ifu_rs2_used & (ifu_rs2_idx == exu_rd_idx);
    // x0 is never a real producer, so it can never create a hazard
    assign load_use     = exu_inst_valid & exu_is_load & (exu_rd_idx != 5'd0)
                        & ifu_inst_valid & (rs1_match | rs2_match);

    always_comb begin
        exu_pause        = 1'b0;
        ifu_stall        = 1'b0;
        exu_bubble       = 1'b0;
        ifu_flush        = 1'b0;
        mdu_result_valid = 1'b0;
        if (!rst) begin
            unique case (state)
                RUN: begin
                    if (mdu_start) begin
                        exu_pause = 1'b1;
                        ifu_stall = 1'b1;
                    end else if (redirect_hit) begin
                        ifu_flush  = 1'b1;
                        exu_bubble = 1'b1;
                    end else if (load_use) begin
                        ifu_stall  = 1'b1;
                        exu_bubble = 1'b1;
                    end
                end
                MDU_WAIT: begin
                    exu_pause        = (cnt != 4'd0);
                    ifu_stall        = (cnt != 4'd0);
                    mdu_result_valid = (cnt == 4'd0);
                end
                FLUSH: begin
                    exu_bubble = 1'b1;
                end
                default: begin
                    exu_pause = 1'b0;
                end
            endcase
        end
    end

    assign perf_stall_cnt = rst ? '0 : stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            cnt       <= 4'd0;
            stall_cnt <= '0;
        end else begin
            if (ifu_stall) begin
                stall_cnt <= stall_cnt + CNT_ONE;
            end
            unique case (state)
                RUN: begin
                    if (mdu_start) begin
                        state <= MDU_WAIT;
                        cnt   <= MDU_LOAD;
                    end else if (redirect_hit && (FLUSH_CYCLES > 1)) begin
                        state <= FLUSH;
                        cnt   <= FLUSH_LOAD;
                    end
                end
                MDU_WAIT, FLUSH: begin
                    if (cnt == 4'd0) begin
                        state <= RUN;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    state <= RUN;
                    cnt   <= 4'd0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/core_c1_pipe_ctrl.md
Name: core_c1_pipe_ctrl

Overview:
Pipeline hazard controller for the C1 RV32I core. It produces the hold (exu_pause), bubble and flush controls for the IFU/decode stage and the IFU-to-EXU pipeline register.
- Stalls fetch/decode on load-use hazards.
- Holds the EXU for multi-cycle MDU (mul/div) operations using an internal cycle counter.
- Flushes wrong-path instructions after a redirect (taken branch, jump, trap).
- Keeps a free-running stall-cycle performance counter.

Parameters:
MDU_CYCLES, 4, total cycles an MDU op occupies EX; legal range 2..16.
FLUSH_CYCLES, 2, cycles of bubble injected after a redirect (fetch latency); legal range 1..8.
CNT_W, 32, width of perf_stall_cnt.

Ports:
clk  input  1  core clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
ifu_inst_valid  input  1  decode stage holds a valid instruction.
ifu_rs1_idx  input  5  decode rs1 index.
ifu_rs2_idx  input  5  decode rs2 index.
ifu_rs1_used  input  1  decode instruction reads rs1.
ifu_rs2_used  input  1  decode instruction reads rs2.
exu_inst_valid  input  1  EX stage holds a valid instruction.
exu_rd_idx  input  5  EX destination register.
exu_is_load  input  1  EX instruction is a load.
exu_mdu_op  input  1  EX instruction is MUL/DIV/REM class.
exu_redirect  input  1  EX instruction changes PC (taken branch, jal/jalr, trap, mret).
exu_pause  output  1  hold the IFU-to-EXU register.
ifu_stall  output  1  hold PC and the decode instruction.
exu_bubble  output  1  force the valid loaded into the IFU-to-EXU register to 0.
ifu_flush  output  1  discard in-flight fetch; one pulse per redirect.
mdu_result_valid  output  1  MDU result is final this cycle; EXU may write back.
perf_stall_cnt  output  CNT_W  count of cycles with ifu_stall=1.

Behaviour:
- States: RUN, MDU_WAIT, FLUSH.
- State uses a 4-bit down-counter cnt. rst=1 sets state=RUN, cnt=0, perf_stall_cnt=0.
- While rst=1, all outputs are forced to 0.
- Outputs are combinational from state, cnt and inputs.
- Priority in RUN: MDU > redirect > load-use.
- RUN, MDU start: exu_inst_valid & exu_mdu_op.
  - exu_pause=1, ifu_stall=1.
  - Next state MDU_WAIT with cnt<=MDU_CYCLES-2.
  - Redirect and load-use are ignored this cycle.
- RUN, redirect: exu_inst_valid & exu_redirect & !exu_mdu_op.
  - ifu_flush=1, exu_bubble=1, ifu_stall=0.
  - If FLUSH_CYCLES>1: next state FLUSH with cnt<=FLUSH_CYCLES-2. Otherwise stay in RUN.
  - A load-use hazard in the same cycle is suppressed, because the decode instruction is wrong-path.
- RUN, load-use: exu_inst_valid & exu_is_load & exu_rd_idx!=0 & ifu_inst_valid & ((ifu_rs1_used & ifu_rs1_idx==exu_rd_idx) | (ifu_rs2_used & ifu_rs2_idx==exu_rd_idx)).
  - ifu_stall=1, exu_bubble=1, exu_pause=0.
  - Exactly one bubble; state stays RUN. Next cycle the load has left EX, so the hazard clears.
- MDU_WAIT:
  - exu_pause = ifu_stall = (cnt!=0).
  - While cnt!=0: cnt decrements.
  - When cnt==0: mdu_result_valid=1, pause released, next state RUN. The register loads the next instruction at this edge.
  - Redirect and load-use are not evaluated in MDU_WAIT.
  - Net effect: the MDU op occupies EX for exactly MDU_CYCLES cycles, of which exu_pause is high for MDU_CYCLES-1.
- FLUSH:
  - exu_bubble=1, ifu_flush=0, ifu_stall=0.
  - cnt decrements; when cnt==0, next state RUN.
  - New redirects cannot occur because EX holds bubbles.
- mdu_result_valid is 0 in RUN and FLUSH.
- perf_stall_cnt increments by 1 each cycle ifu_stall=1, with modulo-2^CNT_W wrap (all-ones -> 0).
- Reset mid-operation (e.g. in MDU_WAIT with cnt=2): the next cycle is in RUN with pause=0. Any pending MDU op is abandoned; the EXU is reset in the same cycle.
- Hazard checks never match x0 (exu_rd_idx==0 is excluded).

Test Plan:
- Load-use: EX lw x5 valid; decode add x6,x5,x1 with rs1_used=1 -> ifu_stall=1 and exu_bubble=1 for exactly 1 cycle, exu_pause=0, perf_stall_cnt 0->1. Repeat with rd=x0 -> no stall.
- MDU, MDU_CYCLES=4: div enters EX at cycle T -> exu_pause=1 at T, T+1, T+2; 0 at T+3; mdu_result_valid=1 only at T+3; perf_stall_cnt +3.
- Redirect, FLUSH_CYCLES=2: taken beq in EX at T -> ifu_flush=1 only at T; exu_bubble=1 at T and T+1; RUN at T+2. Same-cycle load-use match -> ifu_stall=0.
- Simultaneous exu_mdu_op=1 and exu_redirect=1 -> MDU path wins: exu_pause=1, ifu_flush=0.
- rst=1 asserted in MDU_WAIT with cnt=2 -> next cycle all outputs 0, perf_stall_cnt=0. After release a new MDU op gets a full 3-cycle pause.
- CNT_W=4 wrap: 17 consecutive stall cycles from reset -> perf_stall_cnt goes 15 then 0 then 1.
